// File: rtl/cdb_pkg.sv
// Shared constants, result-entry type and round-robin helper for the CDB arbiter.
package cdb_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROB_W  = 5;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              regdest;
        logic [ROB_W-1:0]  rob_id;
    } cdb_entry_t;

    // Pointer to the source after the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned winner, input int unsigned n);
        return (winner + 1 >= n) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result bus and CDB broadcast bus of the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned N_FU = 3
) ();
    import cdb_pkg::*;

    logic [N_FU-1:0]        fu_valid;
    logic [N_FU-1:0]        fu_ready;
    logic [N_FU*TAG_W-1:0]  fu_tag;
    logic [N_FU*DATA_W-1:0] fu_data;
    logic [N_FU-1:0]        fu_regdest;
    logic [N_FU*ROB_W-1:0]  fu_rob_id;

    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic                   cdb_regdest;
    logic [ROB_W-1:0]       cdb_rob_id;

    // Producer/consumer side: FUs offering results and PRF/ROB/RS receiving broadcasts.
    modport master (
        output fu_valid, fu_tag, fu_data, fu_regdest, fu_rob_id,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_regdest, cdb_rob_id
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data, fu_regdest, fu_rob_id,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_regdest, cdb_rob_id
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-FU result queue: DEPTH-entry FIFO with occupancy count and synchronous flush.
module cdb_fifo import cdb_pkg::*; #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  cdb_entry_t    wr_entry,
    output cdb_entry_t    head,
    output logic          empty,
    output logic [CW-1:0] count
);

    cdb_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Fullness is judged on the pre-edge count, so a full queue never takes a push
    // in the cycle it pops.
    assign do_push = push && (count < CW'(DEPTH)) && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter feeding the PRF write port, ROB and RS.
// Define CDB_FWD_EN to add the two-port operand-forwarding window.
module cdb_arbiter import cdb_pkg::*; #(
    parameter int unsigned N_FU  = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    cdb_arbiter_if.slave      bus
`ifdef CDB_FWD_EN
    ,
    input  logic [TAG_W-1:0]  rd_tag_rs,
    input  logic [TAG_W-1:0]  rd_tag_rt,
    output logic              fwd_hit_rs,
    output logic              fwd_hit_rt,
    output logic [DATA_W-1:0] fwd_data_rs,
    output logic [DATA_W-1:0] fwd_data_rt
`endif
);

    localparam int unsigned PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    cdb_entry_t       heads  [N_FU];
    logic [CW-1:0]    counts [N_FU];
    logic [N_FU-1:0]  empty;
    logic [N_FU-1:0]  pop;

    logic             grant;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] rr_ptr;
    cdb_entry_t       win_entry;

    logic             cdb_vld;
    cdb_entry_t       cdb_out;

    for (genvar i = 0; i < N_FU; i++) begin : g_fifo
        cdb_entry_t wr_entry;

        assign wr_entry = '{
            tag:     bus.fu_tag[i*TAG_W +: TAG_W],
            data:    bus.fu_data[i*DATA_W +: DATA_W],
            regdest: bus.fu_regdest[i],
            rob_id:  bus.fu_rob_id[i*ROB_W +: ROB_W]
        };

        cdb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (bus.fu_valid[i]),
            .pop      (pop[i]),
            .wr_entry (wr_entry),
            .head     (heads[i]),
            .empty    (empty[i]),
            .count    (counts[i])
        );

        assign bus.fu_ready[i] = (counts[i] < CW'(DEPTH));
    end

    // First non-empty queue scanning upward from rr_ptr, modulo N_FU.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % N_FU);
            if (!grant && !empty[idx]) begin
                grant  = 1'b1;
                winner = idx;
            end
        end
    end

    assign win_entry = heads[winner];

    always_comb begin
        pop = '0;
        if (grant && !flush) pop[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            cdb_vld <= 1'b0;
            cdb_out <= '0;
        end else if (flush) begin
            rr_ptr  <= '0;
            cdb_vld <= 1'b0;
        end else if (grant) begin
            rr_ptr          <= PTR_W'(rr_next(32'(winner), N_FU));
            cdb_vld         <= 1'b1;
            cdb_out.tag     <= win_entry.tag;
            cdb_out.data    <= win_entry.data;
            // Physical register 0 is never written.
            cdb_out.regdest <= win_entry.regdest && (win_entry.tag != '0);
            cdb_out.rob_id  <= win_entry.rob_id;
        end else begin
            cdb_vld <= 1'b0;
        end
    end

    assign bus.cdb_valid   = cdb_vld;
    assign bus.cdb_tag     = cdb_out.tag;
    assign bus.cdb_data    = cdb_out.data;
    assign bus.cdb_regdest = cdb_out.regdest;
    assign bus.cdb_rob_id  = cdb_out.rob_id;

`ifdef CDB_FWD_EN
    logic [TAG_W-1:0]  held_tag;
    logic [DATA_W-1:0] held_data;
    logic              held_vld;
    logic              cur_wr;

    assign cur_wr = cdb_vld && cdb_out.regdest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_tag  <= '0;
            held_data <= '0;
            held_vld  <= 1'b0;
        end else if (flush) begin
            held_vld  <= 1'b0;
        end else begin
            held_tag  <= cdb_out.tag;
            held_data <= cdb_out.data;
            held_vld  <= cur_wr;
        end
    end

    // The live broadcast is newer than the held entry, so it wins on a double match.
    always_comb begin
        fwd_hit_rs  = 1'b0;
        fwd_data_rs = '0;
        if (rd_tag_rs != '0) begin
            if (cur_wr && cdb_out.tag == rd_tag_rs) begin
                fwd_hit_rs  = 1'b1;
                fwd_data_rs = cdb_out.data;
            end else if (held_vld && held_tag == rd_tag_rs) begin
                fwd_hit_rs  = 1'b1;
                fwd_data_rs = held_data;
            end
        end
    end

    always_comb begin
        fwd_hit_rt  = 1'b0;
        fwd_data_rt = '0;
        if (rd_tag_rt != '0) begin
            if (cur_wr && cdb_out.tag == rd_tag_rt) begin
                fwd_hit_rt  = 1'b1;
                fwd_data_rt = cdb_out.data;
            end else if (held_vld && held_tag == rd_tag_rt) begin
                fwd_hit_rt  = 1'b1;
                fwd_data_rt = held_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus backpressure, flush and reset sequences.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk;
    logic rst;
    logic flush;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter_if #(.N_FU(3)) bus ();

`ifdef CDB_FWD_EN
    logic [TAG_W-1:0]  rd_tag_rs;
    logic [TAG_W-1:0]  rd_tag_rt;
    logic              fwd_hit_rs;
    logic              fwd_hit_rt;
    logic [DATA_W-1:0] fwd_data_rs;
    logic [DATA_W-1:0] fwd_data_rt;
`endif

    cdb_arbiter #(
        .N_FU  (3),
        .DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus)
`ifdef CDB_FWD_EN
        ,
        .rd_tag_rs   (rd_tag_rs),
        .rd_tag_rt   (rd_tag_rt),
        .fwd_hit_rs  (fwd_hit_rs),
        .fwd_hit_rt  (fwd_hit_rt),
        .fwd_data_rs (fwd_data_rs),
        .fwd_data_rt (fwd_data_rt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fl;
        logic [2:0]  valid;
        logic [17:0] tag;
        logic [95:0] data;
        logic [2:0]  rd;
        logic [14:0] rob;
        logic        e_valid;
        logic [5:0]  e_tag;
        logic [31:0] e_data;
        logic        e_rd;
        logic [4:0]  e_rob;
        logic [2:0]  e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fu();
        bus.fu_valid   = '0;
        bus.fu_tag     = '0;
        bus.fu_data    = '0;
        bus.fu_regdest = '0;
        bus.fu_rob_id  = '0;
    endtask

    task automatic drive_fu(input int i, input logic [5:0] tag, input logic [31:0] data,
                            input logic rd, input logic [4:0] rob);
        bus.fu_valid[i]         = 1'b1;
        bus.fu_tag[i*6 +: 6]    = tag;
        bus.fu_data[i*32 +: 32] = data;
        bus.fu_regdest[i]       = rd;
        bus.fu_rob_id[i*5 +: 5] = rob;
    endtask

    task automatic check_cdb(input string pfx, input logic v, input logic [5:0] t,
                             input logic [31:0] d, input logic r, input logic [4:0] rb);
        check({pfx, ".valid"},   64'(bus.cdb_valid),   64'(v));
        check({pfx, ".tag"},     64'(bus.cdb_tag),     64'(t));
        check({pfx, ".data"},    64'(bus.cdb_data),    64'(d));
        check({pfx, ".regdest"}, 64'(bus.cdb_regdest), 64'(r));
        check({pfx, ".rob"},     64'(bus.cdb_rob_id),  64'(rb));
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    initial begin
        logic [31:0] exp_d;
        logic [3:0]  src;
        logic [3:0]  last_src;
        logic        have_last;
        logic        both_ne;
        logic        any_ne;
        logic        seen_full0;
        logic        known;
        int          seq;
        int          n_push;
        int          n_bcast;

        rst   = 1'b1;
        flush = 1'b0;
        clear_fu();
`ifdef CDB_FWD_EN
        rd_tag_rs = '0;
        rd_tag_rt = '0;
`endif
        #2 rst = 1'b0;
        tick();
        tick();
        check_cdb("reset", 1'b0, 6'h00, 32'h0, 1'b0, 5'd0);
        check("reset.ready", 64'(bus.fu_ready), 64'(3'b111));
        rst = 1'b1;
        tick();
        check("reset.ready_after", 64'(bus.fu_ready), 64'(3'b111));
        check("reset.valid_after", 64'(bus.cdb_valid), 64'd0);

        // Single push latency, flush, 3-way contention, regdest=0 and tag=0 entries.
        vecs.push_back('{1'b0, 3'b010, {6'h00, 6'h05, 6'h00}, {32'h0, 32'hDEADBEEF, 32'h0},
                         3'b010, {5'd0, 5'd3, 5'd0}, 1'b0, 6'h00, 32'h0, 1'b0, 5'd0, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b1, 6'h05, 32'hDEADBEEF, 1'b1, 5'd3, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b0, 6'h05, 32'hDEADBEEF, 1'b1, 5'd3, 3'b111});
        vecs.push_back('{1'b1, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b0, 6'h05, 32'hDEADBEEF, 1'b1, 5'd3, 3'b111});
        vecs.push_back('{1'b0, 3'b111, {6'h13, 6'h12, 6'h11}, {32'h300, 32'h200, 32'h100},
                         3'b111, {5'd4, 5'd2, 5'd1}, 1'b0, 6'h05, 32'hDEADBEEF, 1'b1, 5'd3,
                         3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b1, 6'h11, 32'h100, 1'b1, 5'd1, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b1, 6'h12, 32'h200, 1'b1, 5'd2, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b1, 6'h13, 32'h300, 1'b1, 5'd4, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b0, 6'h13, 32'h300, 1'b1, 5'd4, 3'b111});
        vecs.push_back('{1'b0, 3'b101, {6'h09, 6'h00, 6'h00}, {32'hAAAA, 32'h0, 32'hBBBB},
                         3'b001, {5'd6, 5'd0, 5'd7}, 1'b0, 6'h13, 32'h300, 1'b1, 5'd4,
                         3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b1, 6'h00, 32'hBBBB, 1'b0, 5'd7, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b1, 6'h09, 32'hAAAA, 1'b0, 5'd6, 3'b111});
        vecs.push_back('{1'b0, 3'b000, 18'h0, 96'h0, 3'b000, 15'h0,
                         1'b0, 6'h09, 32'hAAAA, 1'b0, 5'd6, 3'b111});

        foreach (vecs[i]) begin
            flush          = vecs[i].fl;
            bus.fu_valid   = vecs[i].valid;
            bus.fu_tag     = vecs[i].tag;
            bus.fu_data    = vecs[i].data;
            bus.fu_regdest = vecs[i].rd;
            bus.fu_rob_id  = vecs[i].rob;
            tick();
            check_cdb($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_tag,
                      vecs[i].e_data, vecs[i].e_rd, vecs[i].e_rob);
            check($sformatf("vec%0d.ready", i), 64'(bus.fu_ready), 64'(vecs[i].e_ready));
        end
        flush = 1'b0;
        clear_fu();

        // Backpressure: FU0 and FU1 offer every cycle; scoreboard per source.
        seq        = 0;
        n_push     = 0;
        n_bcast    = 0;
        have_last  = 1'b0;
        last_src   = '0;
        both_ne    = 1'b0;
        any_ne     = 1'b0;
        seen_full0 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.cdb_valid) begin
                src   = bus.cdb_data[31:28];
                known = 1'b0;
                exp_d = '0;
                if (src == 4'd0 && q0.size() > 0) begin
                    exp_d = q0.pop_front();
                    known = 1'b1;
                end else if (src == 4'd1 && q1.size() > 0) begin
                    exp_d = q1.pop_front();
                    known = 1'b1;
                end
                check("bp.src_known", 64'(known), 64'd1);
                check("bp.data", 64'(bus.cdb_data), 64'(exp_d));
                check("bp.tag", 64'(bus.cdb_tag), 64'({1'b1, exp_d[4:0]}));
                if (both_ne && have_last) check("bp.alternate", 64'(src != last_src), 64'd1);
                last_src  = src;
                have_last = 1'b1;
                n_bcast++;
            end
            if (any_ne) check("bp.throughput", 64'(bus.cdb_valid), 64'd1);
            check("bp.ready0", 64'(bus.fu_ready[0]), 64'(q0.size() < 2));
            check("bp.ready1", 64'(bus.fu_ready[1]), 64'(q1.size() < 2));
            if (!bus.fu_ready[0]) seen_full0 = 1'b1;
            both_ne = (q0.size() > 0) && (q1.size() > 0);
            any_ne  = (q0.size() > 0) || (q1.size() > 0);
            clear_fu();
            if (cyc < 16) begin
                exp_d = {4'd0, 20'h0, 8'(seq)};
                drive_fu(0, {1'b1, exp_d[4:0]}, exp_d, 1'b1, exp_d[4:0]);
                if (bus.fu_ready[0]) begin
                    q0.push_back(exp_d);
                    n_push++;
                end
                seq++;
                exp_d = {4'd1, 20'h0, 8'(seq)};
                drive_fu(1, {1'b1, exp_d[4:0]}, exp_d, 1'b1, exp_d[4:0]);
                if (bus.fu_ready[1]) begin
                    q1.push_back(exp_d);
                    n_push++;
                end
                seq++;
            end
            tick();
        end
        check("bp.drained0", 64'(q0.size()), 64'd0);
        check("bp.drained1", 64'(q1.size()), 64'd0);
        check("bp.no_loss_dup", 64'(n_bcast), 64'(n_push));
        check("bp.fu0_full_seen", 64'(seen_full0), 64'd1);

        // Flush with queues loaded and a simultaneous push.
        for (int c = 0; c < 3; c++) begin
            for (int f = 0; f < 3; f++) drive_fu(f, 6'h30 + 6'(f), 32'h1000 + 32'(c), 1'b1, 5'd1);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_fu();
        check("flush.valid", 64'(bus.cdb_valid), 64'd0);
        check("flush.ready", 64'(bus.fu_ready), 64'(3'b111));
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("flush.idle%0d", c), 64'(bus.cdb_valid), 64'd0);
            check($sformatf("flush.ready%0d", c), 64'(bus.fu_ready), 64'(3'b111));
        end
        drive_fu(2, 6'h2A, 32'h55, 1'b1, 5'd9);
        tick();
        clear_fu();
        check("flush.post_push", 64'(bus.cdb_valid), 64'd0);
        tick();
        check_cdb("flush.new", 1'b1, 6'h2A, 32'h55, 1'b1, 5'd9);

        // Asynchronous reset in the middle of traffic.
        for (int c = 0; c < 2; c++) begin
            for (int f = 0; f < 3; f++) drive_fu(f, 6'h3C, 32'h77, 1'b1, 5'd2);
            tick();
        end
        check("rstmid.busy", 64'(bus.cdb_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_cdb("rstmid", 1'b0, 6'h00, 32'h0, 1'b0, 5'd0);
        check("rstmid.ready", 64'(bus.fu_ready), 64'(3'b111));
        clear_fu();
        tick();
        rst = 1'b1;
        tick();
        check("rstmid.lost", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("rstmid.lost2", 64'(bus.cdb_valid), 64'd0);

`ifdef CDB_FWD_EN
        rd_tag_rs = 6'd12;
        rd_tag_rt = 6'd0;
        drive_fu(0, 6'd12, 32'd7, 1'b1, 5'd1);
        tick();
        clear_fu();
        check("fwd.before", 64'(fwd_hit_rs), 64'd0);
        tick();
        check("fwd.cur_hit", 64'(fwd_hit_rs), 64'd1);
        check("fwd.cur_data", 64'(fwd_data_rs), 64'd7);
        check("fwd.rt_hit", 64'(fwd_hit_rt), 64'd0);
        check("fwd.rt_data", 64'(fwd_data_rt), 64'd0);
        tick();
        check("fwd.held_hit", 64'(fwd_hit_rs), 64'd1);
        check("fwd.held_data", 64'(fwd_data_rs), 64'd7);
        tick();
        check("fwd.expired_hit", 64'(fwd_hit_rs), 64'd0);
        check("fwd.expired_data", 64'(fwd_data_rs), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Complete-stage Common Data Bus (CDB) arbiter sitting directly upstream of the physical register file.
- Collects results from N_FU functional units (ALU, multiplier, load/store) into small per-unit queues.
- Picks one result per cycle, round-robin.
- Drives the registered broadcast (tag, value, write flag, ROB id) that feeds the PRF write port (p_rd, wr_data_in, RegDest_compl), the ROB and the reservation stations.

Parameters:
N_FU, 3, number of functional-unit result sources
DEPTH, 2, entries per per-FU queue (power of two, >=2)
TAG_W, 6, physical register tag width (64 physical registers)
DATA_W, 32, result width
ROB_W, 5, ROB index width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  mispredict/exception flush; synchronous clear of all queued results
fu_valid  in  N_FU  result offered by FU i
fu_ready  out  N_FU  queue i not full; a push occurs when fu_valid[i] & fu_ready[i]
fu_tag  in  N_FU*TAG_W  destination physical tag, FU i at slice [i*TAG_W +: TAG_W]
fu_data  in  N_FU*DATA_W  result value per FU
fu_regdest  in  N_FU  1 if the instruction writes a register
fu_rob_id  in  N_FU*ROB_W  ROB index per FU
cdb_valid  out  1  broadcast valid this cycle
cdb_tag  out  TAG_W  broadcast tag (to PRF p_rd)
cdb_data  out  DATA_W  broadcast value (to PRF wr_data_in)
cdb_regdest  out  1  PRF write qualifier (to PRF RegDest_compl)
cdb_rob_id  out  ROB_W  ROB entry to mark complete

Behaviour:
- Reset (rst low, asynchronous): all queues empty; rr_ptr=0; cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_regdest=0, cdb_rob_id=0; fu_ready=all ones once rst deasserts.
- Queues: each is a FIFO of {tag,data,regdest,rob_id} with read/write pointers and an occupancy count 0..DEPTH.
  - fu_ready[i] = (count_i < DEPTH), combinational from count only.
  - A full queue does not accept input in the same cycle it pops; no pass-through.
- Arbitration (combinational, on queue heads): the winner is the first non-empty queue found scanning i = rr_ptr, rr_ptr+1, … modulo N_FU.
  - On a grant, the winner's queue pops at the clock edge and rr_ptr <= (winner+1) mod N_FU.
  - With no non-empty queue: no pop, rr_ptr holds, cdb_valid <= 0 and the other cdb_* outputs hold their last values.
- Output register: the winner's head is loaded into cdb_* with cdb_valid <= 1 for exactly one cycle per entry.
- Latency: a result pushed at edge E0 is at the head after E0 and, if it wins, appears on cdb_* after E1. Minimum latency is 2 edges.
- Throughput: 1 broadcast per cycle. No starvation: each non-empty queue is granted within N_FU cycles.
- Simultaneous push and pop on the same queue: both take effect; count is unchanged.
- Entries with regdest=0 (stores, branches) are still broadcast, so the ROB completes them; cdb_regdest=0 suppresses the PRF write.
- Entries with regdest=1 and tag=0 are broadcast with cdb_regdest forced to 0; physical register 0 is never written.
- flush: at the next edge, all counts/pointers clear, cdb_valid <= 0, rr_ptr <= 0, and pushes in that cycle are discarded. flush overrides simultaneous grants.
- Reset mid-operation: all state cleared immediately; queued results are lost by design.

Optional Feature:
- Macro: CDB_FWD_EN.
- When defined, the block adds operand forwarding for the PRF's read-after-write window:
  - Extra inputs: rd_tag_rs, rd_tag_rt (TAG_W each).
  - Extra outputs: fwd_hit_rs, fwd_hit_rt (1) and fwd_data_rs, fwd_data_rt (DATA_W).
  - A one-entry register holds the previous cycle's {cdb_tag, cdb_data, cdb_valid & cdb_regdest}.
  - fwd_hit_x = current broadcast (cdb_valid & cdb_regdest & cdb_tag==rd_tag_x) OR held entry match. The current broadcast takes priority over the held entry.
  - fwd_data_x selects the matching value; it is 0 when no hit.
  - Tag 0 never hits.
  - Reset and flush clear the held entry.
- When not defined, these ports and registers do not exist; the consumer reads the PRF only.

Decomposition:
- Package cdb_pkg holds:
  - TAG_W, DATA_W, ROB_W constants.
  - typedef cdb_entry_t {tag, data, regdest, rob_id}.
  - The round-robin next-pointer function.
- Sub-module cdb_fifo: one per FU via generate; parameter DEPTH; push/pop/flush interface; exposes head, empty, count.

Test Plan:
1. Reset then single push: FU1 tag=6'h05, data=32'hDEADBEEF, regdest=1, rob=3 at edge E0 -> after E1 cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_regdest=1, cdb_rob_id=3; after E2 cdb_valid=0.
2. Contention: all 3 FUs push one entry at the same edge with rr_ptr=0 -> broadcasts in order FU0, FU1, FU2 on 3 consecutive cycles; rr_ptr ends at 0.
3. Backpressure: FU0 pushes every cycle while FU1 is also kept non-empty -> FU0 queue fills and fu_ready[0]=0 when count=2; FU0/FU1 grants alternate; no entry is lost or duplicated (scoreboard check).
4. Special entries: regdest=0 with tag=9 -> cdb_valid=1, cdb_regdest=0; regdest=1 with tag=0 -> cdb_regdest=0.
5. Flush with 2 entries queued in each FU, plus a simultaneous push -> next cycle cdb_valid=0, all fu_ready=1, and no broadcast until a new push.
6. CDB_FWD_EN: broadcast tag=12/data=7 while rd_tag_rs=12 -> fwd_hit_rs=1, fwd_data_rs=7 that cycle and the next; with rd_tag_rt=0 -> fwd_hit_rt=0.
